fetch_queue: RTL and testbench

//  Dual-wide in-order instruction queue between fetch and the two decoder slots.

---
 rtl/fetch_queue_pkg.sv | 39 +++
 rtl/fetch_queue_mem.sv | 46 ++++
 rtl/fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared types and helpers for the dual-wide fetch queue.
//   - fq_entry_t   : one queued {pc, instruction} pair (pc in the upper half)
//   - push_mask_e  : encodings of the two-bit fetch valid mask
//   - push_count() : number of entries a legal valid mask delivers
//   - min2()       : two-bit minimum used when clipping pops
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int FQ_XLEN     = 32;
   localparam int FQ_ENTRY_W  = 2 * FQ_XLEN;

   // pc occupies [63:32], instruction occupies [31:0]
   typedef struct packed {
      logic [FQ_XLEN-1:0] pc;
      logic [FQ_XLEN-1:0] inst;
   } fq_entry_t;

   typedef enum logic [1:0] {
      PUSH_NONE    = 2'b00,
      PUSH_ONE     = 2'b01,
      PUSH_ILLEGAL = 2'b10,
      PUSH_TWO     = 2'b11
   } push_mask_e;

   function automatic logic [1:0] push_count(input logic [1:0] mask);
      case (push_mask_e'(mask))
         PUSH_ONE: return 2'd1;
         PUSH_TWO: return 2'd2;
         default:  return 2'd0;   // slot 1 without slot 0 delivers nothing
      endcase
   endfunction

   function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// -----------------------------------------------------------------------------
// fetch_queue_mem
//   DEPTH x fq_entry_t register array for the fetch queue.
//   Two synchronous write ports, two asynchronous read ports. The queue
//   controller never targets the same address with both write ports in one
//   cycle; if it did, port 1 would win.
// Ports
//   clk_i            clock, rising edge
//   we0_i/we1_i      write enables
//   waddr0_i/1_i     write addresses
//   wdata0_i/1_i     write data
//   raddr0_i/1_i     read addresses
//   rdata0_o/1_o     read data (combinational)
// -----------------------------------------------------------------------------
module fetch_queue_mem
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we0_i,
   input  logic [PTR_W-1:0] waddr0_i,
   input  fq_entry_t        wdata0_i,
   input  logic             we1_i,
   input  logic [PTR_W-1:0] waddr1_i,
   input  fq_entry_t        wdata1_i,
   input  logic [PTR_W-1:0] raddr0_i,
   output fq_entry_t        rdata0_o,
   input  logic [PTR_W-1:0] raddr1_i,
   output fq_entry_t        rdata1_o
);

   fq_entry_t mem_q [DEPTH];

   // NOTE: the array has no reset; occupancy lives in the controller's count,
   // so stale contents are never observed and the array stays plain flops.
   always_ff @(posedge clk_i) begin
      if (we0_i) mem_q[waddr0_i] <= wdata0_i;
      if (we1_i) mem_q[waddr1_i] <= wdata1_i;
   end

   assign rdata0_o = mem_q[raddr0_i];
   assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Dual-wide in-order instruction queue between fetch and the two decoder
//   slots. Accepts up to two {pc, inst} pairs per cycle, presents the two
//   oldest to decode, and flushes everything in one cycle on a redirect.
//   Optional macro FETCHQ_BYPASS_EN: when the queue is empty (and not being
//   flushed) fetch data is forwarded combinationally to decode.
// Ports
//   clk_i, rst_ni          clock / asynchronous active-low reset
//   flush_i                drop all entries (wins over push and pop)
//   push_valid_i[1:0]      fetch slot valid, [0] older; 2'b10 is illegal
//   push_pc0/1_i, push_inst0/1_i   fetch slot payloads
//   push_ready_o           at least two free entries (registered state only)
//   dec_valid_o[1:0]       decode slot valid
//   dec_pc0/1_o, dec_inst0/1_o     oldest / second-oldest entry, 0 if invalid
//   pop_i[1:0]             entries consumed this cycle (clipped to valid)
//   count_o                current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic [1:0]       push_valid_i,
   input  logic [31:0]      push_pc0_i,
   input  logic [31:0]      push_inst0_i,
   input  logic [31:0]      push_pc1_i,
   input  logic [31:0]      push_inst1_i,
   output logic             push_ready_o,
   output logic [1:0]       dec_valid_o,
   output logic [31:0]      dec_pc0_o,
   output logic [31:0]      dec_inst0_o,
   output logic [31:0]      dec_pc1_o,
   output logic [31:0]      dec_inst1_o,
   input  logic [1:0]       pop_i,
   output logic [PTR_W:0]   count_o
);

   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
   localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic [1:0]       push_mask;
   logic [1:0]       n_push;
   logic [1:0]       n_avail;
   logic [1:0]       n_pop;
   logic [1:0]       n_wr;
   logic [1:0]       dec_valid;
   fq_entry_t        push_e0, push_e1;
   fq_entry_t        dec_e0, dec_e1;
   fq_entry_t        rdata0, rdata1;
   fq_entry_t        wdata0, wdata1;
   logic             we0, we1;
   logic [PTR_W-1:0] waddr0, waddr1;
`ifdef FETCHQ_BYPASS_EN
   logic             bypass_act;
`endif

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk_i    (clk_i),
      .we0_i    (we0),
      .waddr0_i (waddr0),
      .wdata0_i (wdata0),
      .we1_i    (we1),
      .waddr1_i (waddr1),
      .wdata1_i (wdata1),
      .raddr0_i (rd_ptr_q),
      .rdata0_o (rdata0),
      .raddr1_i (rd_ptr_q + PTR_ONE),
      .rdata1_o (rdata1)
   );

   // NOTE: every signal gets a default at the top of the block so no path
   // leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      push_mask    = (push_valid_i == PUSH_ILLEGAL) ? 2'b00 : push_valid_i;
      push_ready_o = (count_q <= READY_MAX);
      n_push       = push_ready_o ? push_count(push_mask) : 2'd0;
      push_e0      = '{pc: push_pc0_i, inst: push_inst0_i};
      push_e1      = '{pc: push_pc1_i, inst: push_inst1_i};

      // Registered view: slots valid by occupancy, invalid slots read as zero
      dec_valid = {count_q >= CNT_TWO, count_q >= CNT_ONE};
      dec_e0    = dec_valid[0] ? rdata0 : '0;
      dec_e1    = dec_valid[1] ? rdata1 : '0;
      n_avail   = (count_q >= CNT_TWO) ? 2'd2 : count_q[1:0];

      // Writes go to consecutive slots starting at wr_ptr
      n_wr   = n_push;
      we0    = (n_push != 2'd0);
      we1    = (n_push == 2'd2);
      waddr0 = wr_ptr_q;
      waddr1 = wr_ptr_q + PTR_ONE;
      wdata0 = push_e0;
      wdata1 = push_e1;

`ifdef FETCHQ_BYPASS_EN
      bypass_act = (count_q == '0) && !flush_i;
      if (bypass_act) begin
         dec_valid = push_mask;
         dec_e0    = push_mask[0] ? push_e0 : '0;
         dec_e1    = push_mask[1] ? push_e1 : '0;
         n_avail   = n_push;
      end
`endif

      n_pop    = min2(pop_i, n_avail);
      rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);

`ifdef FETCHQ_BYPASS_EN
      // Entries consumed straight from fetch never touch the array; only the
      // unpopped remainder is written, and rd_ptr stays aligned with wr_ptr.
      if (bypass_act) begin
         n_wr     = n_push - n_pop;
         we0      = (n_wr != 2'd0);
         we1      = (n_wr == 2'd2);
         wdata0   = (n_pop == 2'd1) ? push_e1 : push_e0;
         rd_ptr_d = rd_ptr_q;
      end
`endif

      wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
      count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);

      // Redirect: wrong-path pushes are dropped and the read side catches up
      if (flush_i) begin
         we0      = 1'b0;
         we1      = 1'b0;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dec_valid_o = dec_valid;
   assign dec_pc0_o   = dec_e0.pc;
   assign dec_inst0_o = dec_e0.inst;
   assign dec_pc1_o   = dec_e1.pc;
   assign dec_inst1_o = dec_e1.inst;
   assign count_o     = count_q;

   illegal_push_mask_a : assert property (
      @(posedge clk_i) disable iff (!rst_ni) push_valid_i != PUSH_ILLEGAL
   ) else $error("fetch_queue: push_valid_i=2'b10 is illegal");

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed scenarios plus a randomized run of fetch_queue, checked against
//   an in-bench model kept as a plain queue of {pc, inst} entries.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic [1:0]  push_valid_i = 2'b00;
   logic [31:0] push_pc0_i = '0, push_inst0_i = '0, push_pc1_i = '0, push_inst1_i = '0;
   logic [1:0]  pop_i = 2'b00;
   logic        push_ready_o;
   logic [1:0]  dec_valid_o;
   logic [31:0] dec_pc0_o, dec_inst0_o, dec_pc1_o, dec_inst1_o;
   logic [3:0]  count_o;

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t model_q[$];

   always #5 clk_i = ~clk_i;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .push_valid_i (push_valid_i),
      .push_pc0_i   (push_pc0_i),
      .push_inst0_i (push_inst0_i),
      .push_pc1_i   (push_pc1_i),
      .push_inst1_i (push_inst1_i),
      .push_ready_o (push_ready_o),
      .dec_valid_o  (dec_valid_o),
      .dec_pc0_o    (dec_pc0_o),
      .dec_inst0_o  (dec_inst0_o),
      .dec_pc1_o    (dec_pc1_o),
      .dec_inst1_o  (dec_inst1_o),
      .pop_i        (pop_i),
      .count_o      (count_o)
   );

   task automatic drive(input logic [1:0] pv, input logic [1:0] pop, input logic fl,
                        input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] pc1, input logic [31:0] i1);
      push_valid_i = pv;
      pop_i        = pop;
      flush_i      = fl;
      push_pc0_i   = pc0;
      push_inst0_i = i0;
      push_pc1_i   = pc1;
      push_inst1_i = i1;
   endtask

   // One clock: model applies the queue rules to the inputs seen at the edge,
   // then inputs go idle and control returns at the following falling edge.
   task automatic tick();
      int n_push, n_pop, avail;
      @(posedge clk_i);
      if (flush_i) begin
         model_q.delete();
      end else begin
         n_push = 0;
         if (model_q.size() <= DEPTH - 2) begin
            if (push_valid_i == 2'b01) n_push = 1;
            else if (push_valid_i == 2'b11) n_push = 2;
         end
         avail = (model_q.size() >= 2) ? 2 : model_q.size();
`ifdef FETCHQ_BYPASS_EN
         if (model_q.size() == 0) avail = n_push;
`endif
         n_pop = (int'(pop_i) < avail) ? int'(pop_i) : avail;
         if (n_push >= 1) model_q.push_back('{push_pc0_i, push_inst0_i});
         if (n_push == 2) model_q.push_back('{push_pc1_i, push_inst1_i});
         repeat (n_pop) void'(model_q.pop_front());
      end
      #1;
      drive(2'b00, 2'd0, 1'b0, '0, '0, '0, '0);
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      drive(2'b00, 2'd0, 1'b0, '0, '0, '0, '0);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      model_q.delete();
      @(negedge clk_i);
      n_checks++; if (dec_valid_o !== 2'b00) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 00", dec_valid_o); end
      n_checks++; if (dec_inst0_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst0: got %h expected 0", dec_inst0_o); end
      n_checks++; if (dec_pc0_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc0: got %h expected 0", dec_pc0_o); end
      n_checks++; if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", push_ready_o); end
      n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_single_push();
      drive(2'b11, 2'd0, 1'b0, 32'h100, 32'h00500093, 32'h104, 32'h00A00113);
      tick();
      n_checks++; if (dec_valid_o !== 2'b11) begin n_fail++; $display("FAIL push_dec_valid: got %b expected 11", dec_valid_o); end
      n_checks++; if (dec_pc0_o !== 32'h100) begin n_fail++; $display("FAIL push_pc0: got %h expected 100", dec_pc0_o); end
      n_checks++; if (dec_inst0_o !== 32'h00500093) begin n_fail++; $display("FAIL push_inst0: got %h expected 00500093", dec_inst0_o); end
      n_checks++; if (dec_pc1_o !== 32'h104) begin n_fail++; $display("FAIL push_pc1: got %h expected 104", dec_pc1_o); end
      n_checks++; if (dec_inst1_o !== 32'h00A00113) begin n_fail++; $display("FAIL push_inst1: got %h expected 00a00113", dec_inst1_o); end
      n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL push_count: got %0d expected 2", count_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 2'd0, 1'b0, 32'h200 + 8 * k, 32'hA000_0000 + k, 32'h204 + 8 * k, 32'hB000_0000 + k);
         tick();
      end
      n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d expected 8", count_o); end
      n_checks++; if (push_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", push_ready_o); end
      drive(2'b11, 2'd0, 1'b0, 32'h900, 32'h1, 32'h904, 32'h2);
      tick();
      n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL full_ignore_count: got %0d expected 8", count_o); end
      n_checks++; if (dec_pc0_o !== 32'h200) begin n_fail++; $display("FAIL full_ignore_pc0: got %h expected 200", dec_pc0_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd6) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 6", count_o); end
      n_checks++; if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b expected 1", push_ready_o); end
      n_checks++; if (dec_pc0_o !== 32'h208) begin n_fail++; $display("FAIL full_pop_pc0: got %h expected 208", dec_pc0_o); end
   endtask

   // Continues from six entries 0x208..0x21C; array slots 0..7 already used once
   task automatic test_pop_push_boundary();
      drive(2'b01, 2'd0, 1'b0, 32'h300, 32'h3, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd7) begin n_fail++; $display("FAIL seven_count: got %0d expected 7", count_o); end
      n_checks++; if (push_ready_o !== 1'b0) begin n_fail++; $display("FAIL seven_ready: got %b expected 0", push_ready_o); end
      drive(2'b11, 2'd1, 1'b0, 32'h304, 32'h4, 32'h308, 32'h5);
      tick();
      n_checks++; if (count_o !== 4'd6) begin n_fail++; $display("FAIL refused_count: got %0d expected 6", count_o); end
      n_checks++; if (dec_pc0_o !== 32'h20C) begin n_fail++; $display("FAIL refused_pc0: got %h expected 20c", dec_pc0_o); end
      drive(2'b11, 2'd2, 1'b0, 32'h310, 32'h6, 32'h314, 32'h7);
      tick();
      n_checks++; if (count_o !== 4'd6) begin n_fail++; $display("FAIL pushpop_count: got %0d expected 6", count_o); end
      n_checks++; if (dec_pc0_o !== 32'h214 || dec_pc1_o !== 32'h218) begin n_fail++; $display("FAIL pushpop_pcs: got %h/%h expected 214/218", dec_pc0_o, dec_pc1_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (dec_pc0_o !== 32'h21C || dec_pc1_o !== 32'h300) begin n_fail++; $display("FAIL wrap_pcs: got %h/%h expected 21c/300", dec_pc0_o, dec_pc1_o); end
      n_checks++; if (dec_inst1_o !== 32'h3) begin n_fail++; $display("FAIL wrap_inst1: got %h expected 3", dec_inst1_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (dec_pc0_o !== 32'h310 || dec_pc1_o !== 32'h314) begin n_fail++; $display("FAIL wrap2_pcs: got %h/%h expected 310/314", dec_pc0_o, dec_pc1_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin n_fail++; $display("FAIL empty_state: got count %0d valid %b expected 0/00", count_o, dec_valid_o); end
      n_checks++; if (dec_pc0_o !== 32'h0) begin n_fail++; $display("FAIL empty_pc0: got %h expected 0", dec_pc0_o); end
      drive(2'b01, 2'd0, 1'b0, 32'h320, 32'h8, 32'h324, 32'h9);
      tick();
      n_checks++; if (dec_valid_o !== 2'b01 || dec_pc1_o !== 32'h0) begin n_fail++; $display("FAIL one_entry: got valid %b pc1 %h expected 01/0", dec_valid_o, dec_pc1_o); end
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL pop_clip_count: got %0d expected 0", count_o); end
   endtask

   task automatic test_flush();
      drive(2'b11, 2'd0, 1'b0, 32'h400, 32'h10, 32'h404, 32'h11); tick();
      drive(2'b11, 2'd0, 1'b0, 32'h408, 32'h12, 32'h40C, 32'h13); tick();
      drive(2'b01, 2'd0, 1'b0, 32'h410, 32'h14, '0, '0);          tick();
      n_checks++; if (count_o !== 4'd5) begin n_fail++; $display("FAIL preflush_count: got %0d expected 5", count_o); end
      drive(2'b11, 2'd2, 1'b1, 32'h480, 32'h15, 32'h484, 32'h16);
      tick();
      n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_o); end
      n_checks++; if (dec_valid_o !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b expected 00", dec_valid_o); end
      n_checks++; if (push_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", push_ready_o); end
      drive(2'b01, 2'd0, 1'b0, 32'h500, 32'h17, '0, '0);
      tick();
      n_checks++; if (count_o !== 4'd1 || dec_pc0_o !== 32'h500) begin n_fail++; $display("FAIL postflush: got count %0d pc0 %h expected 1/500", count_o, dec_pc0_o); end
      drive(2'b00, 2'd1, 1'b0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_bypass();
      drive(2'b01, 2'd1, 1'b0, 32'h600, 32'h0000006F, '0, '0);
      #1;
`ifdef FETCHQ_BYPASS_EN
      n_checks++; if (dec_valid_o !== 2'b01) begin n_fail++; $display("FAIL bypass_valid: got %b expected 01", dec_valid_o); end
      n_checks++; if (dec_inst0_o !== 32'h0000006F) begin n_fail++; $display("FAIL bypass_inst0: got %h expected 6f", dec_inst0_o); end
      tick();
      n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", count_o); end
      drive(2'b11, 2'd1, 1'b0, 32'h610, 32'h20, 32'h614, 32'h21);
      tick();
      n_checks++; if (count_o !== 4'd1 || dec_pc0_o !== 32'h614) begin n_fail++; $display("FAIL bypass_rem: got count %0d pc0 %h expected 1/614", count_o, dec_pc0_o); end
`else
      n_checks++; if (dec_valid_o !== 2'b00) begin n_fail++; $display("FAIL nobypass_valid: got %b expected 00", dec_valid_o); end
      n_checks++; if (dec_inst0_o !== 32'h0) begin n_fail++; $display("FAIL nobypass_inst0: got %h expected 0", dec_inst0_o); end
      tick();
      n_checks++; if (count_o !== 4'd1 || dec_inst0_o !== 32'h0000006F) begin n_fail++; $display("FAIL nobypass_next: got count %0d inst0 %h expected 1/6f", count_o, dec_inst0_o); end
`endif
      drive(2'b00, 2'd2, 1'b0, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_async_reset();
      drive(2'b11, 2'd0, 1'b0, 32'h700, 32'h30, 32'h704, 32'h31); tick();
      drive(2'b01, 2'd0, 1'b0, 32'h708, 32'h32, '0, '0);          tick();
      n_checks++; if (count_o !== 4'd3) begin n_fail++; $display("FAIL prereset_count: got %0d expected 3", count_o); end
      #2 rst_ni = 1'b0;
      #1;
      n_checks++; if (count_o !== 4'd0 || dec_valid_o !== 2'b00) begin n_fail++; $display("FAIL async_reset: got count %0d valid %b expected 0/00", count_o, dec_valid_o); end
      model_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_random();
      int r;
      int sz;
      logic [1:0]  pv;
      logic [31:0] e_pc0, e_i0, e_pc1, e_i1;
      for (int c = 0; c < 400; c++) begin
         sz    = model_q.size();
         e_pc0 = (sz >= 1) ? model_q[0].pc   : 32'h0;
         e_i0  = (sz >= 1) ? model_q[0].inst : 32'h0;
         e_pc1 = (sz >= 2) ? model_q[1].pc   : 32'h0;
         e_i1  = (sz >= 2) ? model_q[1].inst : 32'h0;
         n_checks++; if (int'(count_o) !== sz) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, count_o, sz); end
         n_checks++; if (push_ready_o !== (sz <= DEPTH - 2)) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, push_ready_o, (sz <= DEPTH - 2)); end
         n_checks++; if (dec_valid_o !== {sz >= 2, sz >= 1}) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b size %0d", c, dec_valid_o, sz); end
         n_checks++; if (dec_pc0_o !== e_pc0 || dec_inst0_o !== e_i0) begin n_fail++; $display("FAIL rand_slot0[%0d]: got %h:%h expected %h:%h", c, dec_pc0_o, dec_inst0_o, e_pc0, e_i0); end
         n_checks++; if (dec_pc1_o !== e_pc1 || dec_inst1_o !== e_i1) begin n_fail++; $display("FAIL rand_slot1[%0d]: got %h:%h expected %h:%h", c, dec_pc1_o, dec_inst1_o, e_pc1, e_i1); end
         r  = $urandom_range(0, 9);
         pv = (r <= 5) ? 2'b11 : (r <= 7) ? 2'b01 : 2'b00;
         drive(pv, 2'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0),
               $urandom, $urandom, $urandom, $urandom);
         tick();
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_push();
      test_fill();
      test_pop_push_boundary();
      test_flush();
      test_bypass();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
